// File: rtl/oled_pixel_streamer_pkg.sv
// Shared types and constants for the OLED pixel streamer.
//   state_t   : streamer FSM states
//   rgb565_t  : 16-bit RGB565 pixel word
//   cmd_byte  : SSD1331 address-window command sequence, byte by index
package oled_pixel_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    typedef logic [15:0] rgb565_t;

    localparam logic [7:0] CMD_SET_COL = 8'h15;
    localparam logic [7:0] CMD_SET_ROW = 8'h75;
    localparam int         N_CMD_BYTES = 6;

    // Window covers the full panel: columns 0..cols-1, rows 0..rows-1.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input int cols, input int rows);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD_SET_COL;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'(cols - 1);
            3'd3:    b = CMD_SET_ROW;
            3'd4:    b = 8'h00;
            3'd5:    b = 8'(rows - 1);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_pixel_streamer_if.sv
// Bus between the pixel streamer, its font source / controller and the OLED.
//   master : the streamer side (drives coordinates and SPI pins)
//   slave  : the environment side (drives start and pixel_data)
// Parameters XW/YW must match $clog2(Width)/$clog2(Height) of the streamer.
interface oled_pixel_streamer_if #(
    parameter int XW = 7,
    parameter int YW = 6
);
    logic          start;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          frame_begin;
    logic [15:0]   pixel_data;
    logic          sclk;
    logic          mosi;
    logic          cs_n;
    logic          dc;
    logic          busy;
    logic          frame_done;

    modport master (
        input  start, pixel_data,
        output x, y, frame_begin, sclk, mosi, cs_n, dc, busy, frame_done
    );

    modport slave (
        output start, pixel_data,
        input  x, y, frame_begin, sclk, mosi, cs_n, dc, busy, frame_done
    );
endinterface

// File: rtl/oled_pixel_streamer_spi_shifter.sv
// SPI mode-3 serialiser: loads an 8- or 16-bit word and shifts it out MSB first.
// Each bit is ClkDiv clk with sclk low followed by ClkDiv clk with sclk high;
// mosi changes together with the sclk falling edge.
// Ports:
//   clk, reset   : system clock, async active-low reset
//   i_load       : capture i_word and start shifting (may coincide with o_done)
//   i_word       : word to send; for bytes only i_word[7:0] is used
//   i_is_byte    : 1 = 8-bit word, 0 = 16-bit word
//   o_sclk/o_mosi: SPI pins, sclk idles high
//   o_done       : high during the last clk of the final sclk-high half
module oled_pixel_streamer_spi_shifter #(
    parameter int ClkDiv = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_word,
    input  logic        i_is_byte,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_done
);
    localparam int             DW      = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [DW-1:0]  DIV_MAX = DW'(ClkDiv - 1);

    logic [15:0]   r_sr;
    logic [3:0]    r_bits;
    logic [DW-1:0] r_div;
    logic          r_active;
    logic          r_sclk;
    logic          r_mosi;
    logic          w_half_end;

    assign w_half_end = (r_div == '0);
    // Asserted combinationally so the next word can be loaded with no gap.
    assign o_done     = r_active && r_sclk && w_half_end && (r_bits == 4'd0);
    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr     <= '0;
            r_bits   <= '0;
            r_div    <= '0;
            r_active <= 1'b0;
            r_sclk   <= 1'b1;
            r_mosi   <= 1'b0;
        end else if (i_load) begin
            r_sr     <= i_is_byte ? {i_word[7:0], 8'h00} : i_word;
            r_bits   <= i_is_byte ? 4'd7 : 4'd15;
            r_div    <= DIV_MAX;
            r_active <= 1'b1;
            r_sclk   <= 1'b0;
            r_mosi   <= i_is_byte ? i_word[7] : i_word[15];
        end else if (r_active) begin
            if (!w_half_end) begin
                r_div <= r_div - DW'(1);
            end else if (!r_sclk) begin
                r_sclk <= 1'b1;
                r_div  <= DIV_MAX;
            end else if (r_bits == 4'd0) begin
                r_active <= 1'b0;
            end else begin
                r_sclk <= 1'b0;
                r_sr   <= {r_sr[14:0], 1'b0};
                r_mosi <= r_sr[14];
                r_bits <= r_bits - 4'd1;
                r_div  <= DIV_MAX;
            end
        end
    end

endmodule

// File: rtl/oled_pixel_streamer.sv
// Streams one full frame from the font source to an SSD1331 OLED over SPI.
// Walks x/y in raster order, captures each RGB565 pixel and serialises it.
// Build option: OLED_CMD_WINDOW_EN adds a 6-byte address-window command
// (dc=0) ahead of every frame; without it the frame starts directly with pixels.
// Ports:
//   clk    : system clock
//   reset  : async active-low reset, aborts any frame immediately
//   bus    : oled_pixel_streamer_if master (start, x, y, frame_begin,
//            pixel_data, sclk, mosi, cs_n, dc, busy, frame_done)
//
// state | meaning
// IDLE  | waiting for start, cs_n high
// CMD   | shifting the address-window command bytes, dc=0
// FETCH | coordinate presented to the font source
// LOAD  | pixel_data captured into the shifter
// SHIFT | 16 pixel bits on the SPI bus
// DONE  | one-cycle frame_done, cs_n released
module oled_pixel_streamer
    import oled_pixel_streamer_pkg::*;
#(
    parameter int Width  = 96,
    parameter int Height = 64,
    parameter int ClkDiv = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    oled_pixel_streamer_if.master bus
);
    localparam int XW = $clog2(Width);
    localparam int YW = $clog2(Height);

    state_t        r_state;
    state_t        w_next;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_load;
    logic          w_is_byte;
    logic          w_done;
    logic          w_last;
    logic          w_pix_phase;
    logic          w_active;
    rgb565_t       w_word;
`ifdef OLED_CMD_WINDOW_EN
    logic [2:0]    r_byte_idx;
`endif

    assign w_last = (r_x == XW'(Width - 1)) && (r_y == YW'(Height - 1));

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_is_byte = 1'b0;
        w_word    = bus.pixel_data;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
`ifdef OLED_CMD_WINDOW_EN
                    w_next    = CMD;
                    w_load    = 1'b1;
                    w_is_byte = 1'b1;
                    w_word    = {8'h00, cmd_byte(3'd0, Width, Height)};
`else
                    w_next    = FETCH;
`endif
                end
            end
`ifdef OLED_CMD_WINDOW_EN
            CMD: begin
                if (w_done) begin
                    if (r_byte_idx == 3'(N_CMD_BYTES - 1)) begin
                        w_next = FETCH;
                    end else begin
                        w_load    = 1'b1;
                        w_is_byte = 1'b1;
                        w_word    = {8'h00, cmd_byte(r_byte_idx + 3'd1, Width, Height)};
                    end
                end
            end
`endif
            FETCH: w_next = LOAD;
            LOAD: begin
                w_load = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                if (w_done) w_next = w_last ? DONE : FETCH;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
`ifdef OLED_CMD_WINDOW_EN
            r_byte_idx <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == SHIFT && w_done) begin
                if (w_last) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (r_x == XW'(Width - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
`ifdef OLED_CMD_WINDOW_EN
            if (r_state == IDLE && bus.start)
                r_byte_idx <= '0;
            else if (r_state == CMD && w_done)
                r_byte_idx <= r_byte_idx + 3'd1;
`endif
        end
    end

    oled_pixel_streamer_spi_shifter #(
        .ClkDiv(ClkDiv)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_word   (w_word),
        .i_is_byte(w_is_byte),
        .o_sclk   (bus.sclk),
        .o_mosi   (bus.mosi),
        .o_done   (w_done)
    );

    assign w_pix_phase     = (r_state == FETCH) || (r_state == LOAD) || (r_state == SHIFT);
    assign w_active        = (r_state != IDLE) && (r_state != DONE);
    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.frame_begin = w_pix_phase;
    assign bus.dc          = w_pix_phase;
    assign bus.cs_n        = !w_active;
    assign bus.busy        = w_active;
    assign bus.frame_done  = (r_state == DONE);

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench for oled_pixel_streamer on a reduced 16x5 panel with ClkDiv=1.
module tb_oled_pixel_streamer;
    localparam int W       = 16;
    localparam int H       = 5;
    localparam int CD      = 1;
    localparam int NPIX    = W * H;
    localparam int PIX_CYC = 2 + 32 * CD;
`ifdef OLED_CMD_WINDOW_EN
    localparam int CMD_CYC = 6 * 16 * CD;
`else
    localparam int CMD_CYC = 0;
`endif
    localparam int FRAME_CYC = NPIX * PIX_CYC + CMD_CYC;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mode    = 0;

    oled_pixel_streamer_if #(.XW(4), .YW(3)) bus_if ();

    oled_pixel_streamer #(
        .Width (W),
        .Height(H),
        .ClkDiv(CD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.master)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] good(input logic [3:0] gx, input logic [2:0] gy);
        return {gx, 1'b0, gy, 8'h5A};
    endfunction

    // SPI receiver: decodes bytes (dc=0) and words (dc=1) on sclk rising edges.
    logic [15:0] mon_sh = '0;
    int          mon_bits = 0;
    logic        mon_prev_sclk = 1'b1;
    logic [15:0] word_q[$];
    logic [3:0]  xq[$];
    logic [2:0]  yq[$];
    logic [7:0]  cmd_q[$];
    int          n_fd = 0;
    int          n_busy = 0;
    int          n_dc0 = 0;

    always @(negedge clk) begin
        if (!reset) begin
            mon_bits      = 0;
            mon_prev_sclk = 1'b1;
        end else begin
            if (bus_if.cs_n) begin
                mon_bits = 0;
            end else if (bus_if.sclk && !mon_prev_sclk) begin
                mon_sh   = {mon_sh[14:0], bus_if.mosi};
                mon_bits = mon_bits + 1;
                if (!bus_if.dc && mon_bits == 8) begin
                    cmd_q.push_back(mon_sh[7:0]);
                    mon_bits = 0;
                end else if (bus_if.dc && mon_bits == 16) begin
                    word_q.push_back(mon_sh);
                    xq.push_back(bus_if.x);
                    yq.push_back(bus_if.y);
                    mon_bits = 0;
                end
            end
            mon_prev_sclk = bus_if.sclk;
            if (bus_if.frame_done) n_fd = n_fd + 1;
            if (bus_if.busy) n_busy = n_busy + 1;
            if (bus_if.busy && !bus_if.dc) n_dc0 = n_dc0 + 1;
        end
    end

    // Font source: mode 0 constant red; mode 1 drives the real pixel only in
    // the LOAD cycle (the cycle after a coordinate appears) and its inverse otherwise.
    logic       f_prev_fb = 1'b0;
    logic       f_prev_fetch = 1'b0;
    logic       f_fetch;
    logic [3:0] f_px = '0;
    logic [2:0] f_py = '0;

    always @(negedge clk) begin
        if (!reset) begin
            f_prev_fb         = 1'b0;
            f_prev_fetch      = 1'b0;
            bus_if.pixel_data = 16'h0000;
        end else begin
            f_fetch = bus_if.frame_begin &&
                      (!f_prev_fb || bus_if.x != f_px || bus_if.y != f_py);
            if (mode == 0)
                bus_if.pixel_data = 16'hF800;
            else if (f_prev_fetch)
                bus_if.pixel_data = good(bus_if.x, bus_if.y);
            else
                bus_if.pixel_data = ~good(bus_if.x, bus_if.y);
            f_prev_fetch = f_fetch;
            f_prev_fb    = bus_if.frame_begin;
            f_px         = bus_if.x;
            f_py         = bus_if.y;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!bus_if.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        repeat (3) tick();
        obs = {bus_if.x[3:0], bus_if.y[2:0], bus_if.frame_begin, bus_if.dc, bus_if.busy, bus_if.frame_done};
        n_tests++;
        if (obs !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_low_outputs got %b want %b", obs, 11'b0);
        end
        obs = {8'b0, bus_if.sclk, bus_if.mosi, bus_if.cs_n};
        n_tests++;
        if (obs !== 11'b101) begin
            n_fail++;
            $display("FAIL reset_spi_pins got %b want %b", obs[2:0], 3'b101);
        end
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (bus_if.busy !== 1'b0 || bus_if.cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_idle got busy=%b cs_n=%b want busy=0 cs_n=1", bus_if.busy, bus_if.cs_n);
        end
    endtask

    task automatic test_red_frame();
        int w0, c0, fd0, b0, d0, bad;
        bit ok;
        logic [15:0] first_bad;
        logic [7:0] exp_cmd[6];
        exp_cmd = '{8'h15, 8'h00, 8'h0F, 8'h75, 8'h00, 8'h04};
        mode = 0;
        w0 = word_q.size(); c0 = cmd_q.size(); fd0 = n_fd; b0 = n_busy; d0 = n_dc0;
        pulse_start();
        wait_idle(FRAME_CYC + 200, ok);
        repeat (3) tick();
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL red_frame_timeout got busy=%b want 0", bus_if.busy);
        end
        n_tests++;
        if (word_q.size() - w0 != NPIX) begin
            n_fail++;
            $display("FAIL red_word_count got %0d want %0d", word_q.size() - w0, NPIX);
        end
        bad = 0;
        first_bad = 16'hF800;
        for (int i = w0; i < word_q.size(); i++) begin
            if (word_q[i] !== 16'hF800) begin
                if (bad == 0) first_bad = word_q[i];
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL red_word_value got %h (%0d bad) want f800", first_bad, bad);
        end
        n_tests++;
        if (n_fd - fd0 != 1) begin
            n_fail++;
            $display("FAIL red_frame_done_count got %0d want 1", n_fd - fd0);
        end
        n_tests++;
        if (n_busy - b0 != FRAME_CYC) begin
            n_fail++;
            $display("FAIL red_busy_cycles got %0d want %0d", n_busy - b0, FRAME_CYC);
        end
        n_tests++;
        if (n_dc0 - d0 != CMD_CYC) begin
            n_fail++;
            $display("FAIL red_dc_low_cycles got %0d want %0d", n_dc0 - d0, CMD_CYC);
        end
`ifdef OLED_CMD_WINDOW_EN
        n_tests++;
        if (cmd_q.size() - c0 != 6) begin
            n_fail++;
            $display("FAIL cmd_byte_count got %0d want 6", cmd_q.size() - c0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (cmd_q[c0 + i] !== exp_cmd[i]) begin
                    n_fail++;
                    $display("FAIL cmd_byte_%0d got %h want %h", i, cmd_q[c0 + i], exp_cmd[i]);
                end
            end
        end
`else
        n_tests++;
        if (cmd_q.size() - c0 != 0) begin
            n_fail++;
            $display("FAIL cmd_bytes_absent got %0d want 0 (first %h vs %h)", cmd_q.size() - c0, cmd_q[c0], exp_cmd[0]);
        end
`endif
    endtask

    task automatic test_raster_capture();
        int w0, n;
        bit ok;
        logic [3:0] ex;
        logic [2:0] ey;
        mode = 1;
        w0 = word_q.size();
        pulse_start();
        wait_idle(FRAME_CYC + 200, ok);
        repeat (3) tick();
        n = word_q.size() - w0;
        n_tests++;
        if (ok !== 1'b1 || n != NPIX) begin
            n_fail++;
            $display("FAIL raster_word_count got %0d want %0d", n, NPIX);
        end
        if (n > NPIX) n = NPIX;
        for (int i = 0; i < n; i++) begin
            ex = 4'(i % W);
            ey = 3'(i / W);
            n_tests++;
            if (xq[w0 + i] !== ex || yq[w0 + i] !== ey) begin
                n_fail++;
                $display("FAIL raster_xy_%0d got (%0d,%0d) want (%0d,%0d)", i, xq[w0 + i], yq[w0 + i], ex, ey);
            end
            n_tests++;
            if (word_q[w0 + i] !== good(ex, ey)) begin
                n_fail++;
                $display("FAIL load_capture_%0d got %h want %h", i, word_q[w0 + i], good(ex, ey));
            end
        end
        mode = 0;
    endtask

    task automatic test_start_ignored();
        int w0, fd0;
        bit ok, found;
        mode = 0;
        w0 = word_q.size(); fd0 = n_fd;
        pulse_start();
        repeat (300) tick();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < FRAME_CYC + 200; i++) begin
            tick();
            if (bus_if.frame_done) begin
                found = 1'b1;
                break;
            end
        end
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        repeat (50) tick();
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_frame_done_seen got %b want 1", found);
        end
        n_tests++;
        if (bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_on_done got busy=%b want 0", bus_if.busy);
        end
        n_tests++;
        if (n_fd - fd0 != 1 || word_q.size() - w0 != NPIX) begin
            n_fail++;
            $display("FAIL ignore_single_frame got done=%0d words=%0d want 1 %0d", n_fd - fd0, word_q.size() - w0, NPIX);
        end
        w0 = word_q.size(); fd0 = n_fd;
        pulse_start();
        wait_idle(FRAME_CYC + 200, ok);
        repeat (3) tick();
        n_tests++;
        if (ok !== 1'b1 || n_fd - fd0 != 1 || word_q.size() - w0 != NPIX) begin
            n_fail++;
            $display("FAIL next_start_frame got ok=%b done=%0d words=%0d want 1 1 %0d", ok, n_fd - fd0, word_q.size() - w0, NPIX);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fd0, w0;
        bit found, ok;
        mode = 0;
        fd0 = n_fd;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            tick();
            if (bus_if.x === 4'd10 && bus_if.y === 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        repeat (4) tick();
        n_tests++;
        if (found !== 1'b1 || bus_if.busy !== 1'b1 || bus_if.sclk !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_setup got found=%b busy=%b sclk=%b want 1 1 0", found, bus_if.busy, bus_if.sclk);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus_if.cs_n !== 1'b1 || bus_if.sclk !== 1'b1 || bus_if.busy !== 1'b0 ||
            bus_if.x !== 4'd0 || bus_if.y !== 3'd0 || bus_if.frame_begin !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate got cs_n=%b sclk=%b busy=%b x=%0d y=%0d fb=%b want 1 1 0 0 0 0",
                     bus_if.cs_n, bus_if.sclk, bus_if.busy, bus_if.x, bus_if.y, bus_if.frame_begin);
        end
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) tick();
        n_tests++;
        if (n_fd != fd0 || bus_if.busy !== 1'b0 || bus_if.cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_done got done=%0d busy=%b cs_n=%b want 0 0 1", n_fd - fd0, bus_if.busy, bus_if.cs_n);
        end
        mode = 1;
        w0 = word_q.size(); fd0 = n_fd;
        pulse_start();
        wait_idle(FRAME_CYC + 200, ok);
        repeat (3) tick();
        n_tests++;
        if (ok !== 1'b1 || n_fd - fd0 != 1 || word_q.size() - w0 != NPIX) begin
            n_fail++;
            $display("FAIL recover_frame got ok=%b done=%0d words=%0d want 1 1 %0d", ok, n_fd - fd0, word_q.size() - w0, NPIX);
        end else begin
            n_tests++;
            if (word_q[w0] !== good(4'd0, 3'd0) || word_q[w0 + NPIX - 1] !== good(4'd15, 3'd4)) begin
                n_fail++;
                $display("FAIL recover_words got %h %h want %h %h", word_q[w0], word_q[w0 + NPIX - 1],
                         good(4'd0, 3'd0), good(4'd15, 3'd4));
            end
        end
        mode = 0;
    endtask

    initial begin
        bus_if.start = 1'b0;
        reset = 1'b0;
        test_reset();
        test_red_frame();
        test_raster_capture();
        test_start_ignored();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
